// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch pushbutton/counter side and stopwatch_ctrl.
// The master drives keys and live digits; the slave (controller) drives run/clear/display.
interface stopwatch_ctrl_if;
    logic       KEY_SS_N;
    logic       KEY_LR_N;
    logic [3:0] MIN;
    logic [3:0] TENSEC;
    logic [3:0] SEC;
    logic [3:0] DECISEC;
    logic [3:0] CENTISEC;
    logic       RUN;
    logic       CLEAR;
    logic       FREEZE;
    logic [3:0] DISP_MIN;
    logic [3:0] DISP_TENSEC;
    logic [3:0] DISP_SEC;
    logic [3:0] DISP_DECISEC;
    logic [3:0] DISP_CENTISEC;
    logic [1:0] STATE;

    modport master (
        output KEY_SS_N, KEY_LR_N, MIN, TENSEC, SEC, DECISEC, CENTISEC,
        input  RUN, CLEAR, FREEZE, STATE,
        input  DISP_MIN, DISP_TENSEC, DISP_SEC, DISP_DECISEC, DISP_CENTISEC
    );

    modport slave (
        input  KEY_SS_N, KEY_LR_N, MIN, TENSEC, SEC, DECISEC, CENTISEC,
        output RUN, CLEAR, FREEZE, STATE,
        output DISP_MIN, DISP_TENSEC, DISP_SEC, DISP_DECISEC, DISP_CENTISEC
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/lap/clear controller: synchronises and debounces two active-low keys,
// sequences counter enable/clear and holds a lap snapshot of the BCD digits.
module stopwatch_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input logic              CLK,
    input logic              RESET_N,
    stopwatch_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        CLEARED = 2'b00,
        RUNNING = 2'b01,
        LAP     = 2'b10,
        STOPPED = 2'b11
    } state_e;

    logic [1:0] key_raw;
    logic [1:0] press;

    assign key_raw = {bus.KEY_LR_N, bus.KEY_SS_N};

    // Bit 0 is start/stop, bit 1 is lap/reset; each gets its own sync/debounce/edge path.
    for (genvar g = 0; g < 2; g++) begin : g_key
        logic             sync1_q, sync1_d;
        logic             sync2_q, sync2_d;
        logic             deb_q, deb_d;
        logic             press_q, press_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            sync1_d = key_raw[g];
            sync2_d = sync1_q;
            deb_d   = deb_q;
            cnt_d   = '0;
            if (sync2_q != deb_q) begin
                if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d = sync2_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // Pulse registered on the same edge the debounced level falls.
            press_d = deb_q & ~deb_d;
        end

        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
                deb_q   <= 1'b1;
                cnt_q   <= '0;
                press_q <= 1'b0;
            end else begin
                sync1_q <= sync1_d;
                sync2_q <= sync2_d;
                deb_q   <= deb_d;
                cnt_q   <= cnt_d;
                press_q <= press_d;
            end
        end

        assign press[g] = press_q;
    end

    logic        ss_ev;
    logic        lr_ev;
    state_e      state_q, state_d;
    logic        run_q, run_d;
    logic        clear_q, clear_d;
    logic [19:0] lap_q, lap_d;
    logic [19:0] live;
    logic [19:0] disp;
    logic        freeze;

    assign ss_ev = press[0];
    assign lr_ev = press[1];
    assign live  = {bus.MIN, bus.TENSEC, bus.SEC, bus.DECISEC, bus.CENTISEC};

    always_comb begin
        state_d = state_q;
        lap_d   = lap_q;
        clear_d = 1'b0;
        // Start/stop wins a same-cycle collision; the lap/reset event is dropped.
        case (state_q)
            CLEARED: begin
                if (ss_ev) state_d = RUNNING;
            end
            RUNNING: begin
                if (ss_ev) begin
                    state_d = STOPPED;
                end else if (lr_ev) begin
                    state_d = LAP;
                    lap_d   = live;
                end
            end
            LAP: begin
                if (ss_ev)      state_d = STOPPED;
                else if (lr_ev) state_d = RUNNING;
            end
            STOPPED: begin
                if (ss_ev) begin
                    state_d = RUNNING;
                end else if (lr_ev) begin
                    state_d = CLEARED;
                    clear_d = 1'b1;
                end
            end
            default: state_d = CLEARED;
        endcase
        run_d = (state_d == RUNNING) || (state_d == LAP);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= CLEARED;
            run_q   <= 1'b0;
            clear_q <= 1'b0;
            lap_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            clear_q <= clear_d;
            lap_q   <= lap_d;
        end
    end

    assign freeze = (state_q == LAP);
    assign disp   = freeze ? lap_q : live;

    assign bus.STATE         = state_q;
    assign bus.RUN           = run_q;
    assign bus.CLEAR         = clear_q;
    assign bus.FREEZE        = freeze;
    assign bus.DISP_MIN      = disp[19:16];
    assign bus.DISP_TENSEC   = disp[15:12];
    assign bus.DISP_SEC      = disp[11:8];
    assign bus.DISP_DECISEC  = disp[7:4];
    assign bus.DISP_CENTISEC = disp[3:0];

endmodule
